// File: rtl/chimera_cluster_pwr_seq.sv
// Shared round-robin power sequencer for the external clusters: drives
// isolation, clock-gate and reset per cluster, one cluster at a time.
//
// state    | meaning
// Idle     | no sequence; arbitrate among pending clusters
// DownIso  | isolation requested, waiting for isolated_i or timeout
// UpRst    | clock running, reset held for ResetCycles
// UpDeiso  | reset released, isolation dropped, waiting for de-isolation
module chimera_cluster_pwr_seq #(
    parameter  int unsigned NumClusters  = 5,
    parameter  int unsigned DrainTimeout = 256,
    parameter  int unsigned ResetCycles  = 4,
    localparam int unsigned IdxW         = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] target_on_i,
    input  logic [NumClusters-1:0] err_clr_i,
    input  logic [NumClusters-1:0] isolated_i,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_o,
    output logic [NumClusters-1:0] cluster_on_o,
    output logic [NumClusters-1:0] err_o,
    output logic                   busy_o,
    output logic [IdxW-1:0]        active_idx_o
);

    // One counter serves both the drain timeout and the reset hold.
    localparam int unsigned     CntSpan   = (DrainTimeout > ResetCycles) ? DrainTimeout : ResetCycles;
    localparam int unsigned     CntW      = $clog2(CntSpan + 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(DrainTimeout - 1);
    localparam logic [CntW-1:0] RstLast   = CntW'(ResetCycles - 1);
    localparam logic [CntW-1:0] CntMax    = {CntW{1'b1}};
    localparam logic [IdxW:0]   NumWide   = (IdxW + 1)'(NumClusters);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumClusters - 1);

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        DownIso = 2'd1,
        UpRst   = 2'd2,
        UpDeiso = 2'd3
    } seqState_e;

    seqState_e              stateQ, stateD;
    logic [CntW-1:0]        cntQ, cntD, cntInc;
    logic [IdxW-1:0]        idxQ, idxD, ptrQ, ptrD;
    logic [NumClusters-1:0] isoQ, isoD, clkEnQ, clkEnD, rstQ, rstD;
    logic [NumClusters-1:0] onQ, onD, errQ, errD;
    logic                   busyQ, busyD;
    logic [NumClusters-1:0] pending;
    logic                   pickValid;
    logic [IdxW-1:0]        pickIdx;
    logic [IdxW:0]          candSum;
    logic                   seqDone;

    assign pending = (target_on_i ^ onQ) & ~errQ;

    // First pending cluster at or after the pointer, wrapping.
    always_comb begin : rrPick
        pickValid = 1'b0;
        pickIdx   = '0;
        candSum   = '0;
        for (int i = 0; i < NumClusters; i++) begin
            candSum = {1'b0, ptrQ} + (IdxW + 1)'(i);
            if (candSum >= NumWide) begin
                candSum = candSum - NumWide;
            end
            if (!pickValid && pending[candSum[IdxW-1:0]]) begin
                pickValid = 1'b1;
                pickIdx   = candSum[IdxW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin : stateReg
        if (rst_i) begin
            stateQ <= Idle;
            cntQ   <= '0;
            idxQ   <= '0;
            ptrQ   <= '0;
            isoQ   <= '1;
            clkEnQ <= '0;
            rstQ   <= '1;
            onQ    <= '0;
            errQ   <= '0;
            busyQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            idxQ   <= idxD;
            ptrQ   <= ptrD;
            isoQ   <= isoD;
            clkEnQ <= clkEnD;
            rstQ   <= rstD;
            onQ    <= onD;
            errQ   <= errD;
            busyQ  <= busyD;
        end
    end

    always_comb begin : nextState
        stateD  = stateQ;
        cntD    = cntQ;
        idxD    = idxQ;
        ptrD    = ptrQ;
        seqDone = 1'b0;
        cntInc  = (cntQ == CntMax) ? cntQ : cntQ + CntW'(1);
        case (stateQ)
            Idle: begin
                if (pickValid) begin
                    idxD   = pickIdx;
                    cntD   = '0;
                    stateD = onQ[pickIdx] ? DownIso : UpRst;
                end
            end
            DownIso: begin
                if (isolated_i[idxQ] || (cntQ == DrainLast)) seqDone = 1'b1;
                else cntD = cntInc;
            end
            UpRst: begin
                if (cntQ == RstLast) begin
                    stateD = UpDeiso;
                    cntD   = '0;
                end else begin
                    cntD = cntInc;
                end
            end
            UpDeiso: begin
                if (!isolated_i[idxQ] || (cntQ == DrainLast)) seqDone = 1'b1;
                else cntD = cntInc;
            end
            default: stateD = Idle;
        endcase
        if (seqDone) begin
            stateD = Idle;
            idxD   = '0;
            ptrD   = (idxQ == LastIdx) ? '0 : idxQ + IdxW'(1);
        end
    end

    // Next values of the registered outputs; only bit idxQ moves mid-sequence.
    always_comb begin : outputNext
        isoD   = isoQ;
        clkEnD = clkEnQ;
        rstD   = rstQ;
        onD    = onQ;
        busyD  = busyQ;
        errD   = errQ & ~err_clr_i;
        case (stateQ)
            Idle: begin
                if (pickValid) begin
                    busyD = 1'b1;
                    if (onQ[pickIdx]) isoD[pickIdx] = 1'b1;
                    else clkEnD[pickIdx] = 1'b1;
                end
            end
            DownIso: begin
                if (isolated_i[idxQ]) begin
                    clkEnD[idxQ] = 1'b0;
                    rstD[idxQ]   = 1'b1;
                    onD[idxQ]    = 1'b0;
                    busyD        = 1'b0;
                end else if (cntQ == DrainLast) begin
                    isoD[idxQ] = 1'b0;
                    errD[idxQ] = 1'b1;
                    busyD      = 1'b0;
                end
            end
            UpRst: begin
                if (cntQ == RstLast) begin
                    rstD[idxQ] = 1'b0;
                    isoD[idxQ] = 1'b0;
                end
            end
            UpDeiso: begin
                if (!isolated_i[idxQ]) begin
                    onD[idxQ] = 1'b1;
                    busyD     = 1'b0;
                end else if (cntQ == DrainLast) begin
                    isoD[idxQ]   = 1'b1;
                    rstD[idxQ]   = 1'b1;
                    clkEnD[idxQ] = 1'b0;
                    errD[idxQ]   = 1'b1;
                    busyD        = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign isolate_o     = isoQ;
    assign clk_en_o      = clkEnQ;
    assign cluster_rst_o = rstQ;
    assign cluster_on_o  = onQ;
    assign err_o         = errQ;
    assign busy_o        = busyQ;
    assign active_idx_o  = idxQ;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Scoreboard bench for chimera_cluster_pwr_seq: every change of the output
// bundle is matched, in order, against a hand-computed (cycle, outputs) entry.
module tb_chimera_cluster_pwr_seq;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int SW = 5 * N + 1 + IW;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  targetOn, errClr, isolated;
    logic [N-1:0]  isolate, clkEn, clusterRst, clusterOn, err;
    logic          busy;
    logic [IW-1:0] activeIdx;

    always #5 clk = ~clk;

    chimera_cluster_pwr_seq #(
        .NumClusters (N),
        .DrainTimeout(8),
        .ResetCycles (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .target_on_i  (targetOn),
        .err_clr_i    (errClr),
        .isolated_i   (isolated),
        .isolate_o    (isolate),
        .clk_en_o     (clkEn),
        .cluster_rst_o(clusterRst),
        .cluster_on_o (clusterOn),
        .err_o        (err),
        .busy_o       (busy),
        .active_idx_o (activeIdx)
    );

    // Cycle index: 0 in the cycle after a sampled reset, +1 per edge after.
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Isolate-unit model: isolated follows isolate with a per-cluster lag.
    logic [7:0]   hist [N] = '{default: 8'hFF};
    int           lag  [N];
    logic [N-1:0] stuck0, stuck1;

    always @(posedge clk) begin
        for (int j = 0; j < N; j++) hist[j] <= {hist[j][6:0], isolate[j]};
    end

    always_comb begin
        isolated = '0;
        for (int j = 0; j < N; j++) begin
            isolated[j] = stuck1[j] | (~stuck0[j] &
                ((lag[j] == 0) ? isolate[j] : hist[j][3'(lag[j] - 1)]));
        end
    end

    typedef struct {
        int          cyc;
        string       name;
        logic [SW-1:0] snap;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;

    logic [N-1:0]  eIso, eClk, eRst, eOn, eErr;
    logic          eBusy;
    logic [IW-1:0] eIdx;

    task automatic expectAt(input int c, input string nm);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.snap = {eIso, eClk, eRst, eOn, eErr, eBusy, eIdx};
        expQ.push_back(e);
    endtask

    task automatic setResetShadow();
        eIso = '1; eClk = '0; eRst = '1; eOn = '0; eErr = '0; eBusy = 1'b0; eIdx = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any change in the output bundle is an event to be matched.
    initial begin
        logic [SW-1:0] snap, prev;
        exp_t e;
        prev = 'x;
        forever begin
            @(negedge clk);
            snap = {isolate, clkEn, clusterRst, clusterOn, err, busy, activeIdx};
            if (snap !== prev) begin
                prev = snap;
                nChecks++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL unexpected_event: got cyc=%0d outputs=%h, required no change", cyc, snap);
                end else begin
                    e = expQ.pop_front();
                    if (e.cyc != cyc || e.snap !== snap) begin
                        nFail++;
                        $display("FAIL %s: got cyc=%0d outputs=%h, required cyc=%0d outputs=%h",
                                 e.name, cyc, snap, e.cyc, e.snap);
                    end
                end
            end
        end
    end

    initial begin
        int t0, t1, p, q;
        rst = 1'b1; targetOn = '0; errClr = '0; stuck0 = '0; stuck1 = '0;
        for (int j = 0; j < N; j++) lag[j] = 2;
        setResetShadow();
        expectAt(0, "reset_state");
        tick(3);
        rst = 1'b0;

        // Power-up cluster 0, isolate model lag 2
        tick(10);
        t0 = cyc; targetOn = 5'b00001;
        eClk[0] = 1'b1; eBusy = 1'b1; eIdx = 0;     expectAt(t0 + 1, "up0_clk_en");
        eRst[0] = 1'b0; eIso[0] = 1'b0;             expectAt(t0 + 5, "up0_rst_release");
        eOn[0] = 1'b1; eBusy = 1'b0;                expectAt(t0 + 8, "up0_commit");
        tick(12);

        // Power-down cluster 0, isolated rises 3 cycles after isolate
        lag[0] = 3;
        t0 = cyc; targetOn = 5'b00000;
        eIso[0] = 1'b1; eBusy = 1'b1; eIdx = 0;     expectAt(t0 + 1, "down0_iso");
        eClk[0] = 1'b0; eRst[0] = 1'b1; eOn[0] = 1'b0; eBusy = 1'b0;
        expectAt(t0 + 5, "down0_commit");
        tick(8);

        // Round-robin power-up of all clusters, ideal isolate model
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int j = 0; j < N; j++) lag[j] = 0;
        t0 = cyc; targetOn = 5'b11111;
        for (int j = 0; j < N; j++) begin
            p = t0 + 1 + 6 * j;
            eClk[j] = 1'b1; eBusy = 1'b1; eIdx = IW'(j); expectAt(p, $sformatf("rr%0d_clk_en", j));
            eRst[j] = 1'b0; eIso[j] = 1'b0;             expectAt(p + 4, $sformatf("rr%0d_rst_release", j));
            eOn[j] = 1'b1; eBusy = 1'b0; eIdx = 0;      expectAt(p + 5, $sformatf("rr%0d_commit", j));
        end
        tick(32);

        // Power-down timeout on cluster 2; clear arrives on the timeout edge
        stuck0[2] = 1'b1;
        t0 = cyc; targetOn = 5'b11011;
        p = t0 + 1;
        eIso[2] = 1'b1; eBusy = 1'b1; eIdx = 2;     expectAt(p, "to2_iso");
        eIso[2] = 1'b0; eErr[2] = 1'b1; eBusy = 1'b0; eIdx = 0;
        expectAt(p + 8, "to2_abort_set_wins");
        tick(8);
        errClr = 5'b00100;
        tick(1);
        errClr = '0;
        tick(10);
        // Clear the error, release the handshake: retry must follow
        t1 = cyc; errClr = 5'b00100; stuck0[2] = 1'b0;
        eErr[2] = 1'b0;                             expectAt(t1 + 1, "to2_err_clear");
        eIso[2] = 1'b1; eBusy = 1'b1; eIdx = 2;     expectAt(t1 + 2, "to2_retry_iso");
        eClk[2] = 1'b0; eRst[2] = 1'b1; eOn[2] = 1'b0; eBusy = 1'b0; eIdx = 0;
        expectAt(t1 + 3, "to2_retry_commit");
        tick(1);
        errClr = '0;
        tick(5);

        // Cluster 1: power down, then power up with target dropped in UpRst
        t0 = cyc; targetOn = 5'b11001;
        eIso[1] = 1'b1; eBusy = 1'b1; eIdx = 1;     expectAt(t0 + 1, "tg1_down_iso");
        eClk[1] = 1'b0; eRst[1] = 1'b1; eOn[1] = 1'b0; eBusy = 1'b0; eIdx = 0;
        expectAt(t0 + 2, "tg1_down_commit");
        tick(4);
        t1 = cyc; targetOn = 5'b11011;
        p = t1 + 1;
        eClk[1] = 1'b1; eBusy = 1'b1; eIdx = 1;     expectAt(p, "tg1_up_clk_en");
        eRst[1] = 1'b0; eIso[1] = 1'b0;             expectAt(p + 4, "tg1_up_rst_release");
        eOn[1] = 1'b1; eBusy = 1'b0; eIdx = 0;      expectAt(p + 5, "tg1_up_commit");
        eIso[1] = 1'b1; eBusy = 1'b1; eIdx = 1;     expectAt(p + 6, "tg1_redown_iso");
        eClk[1] = 1'b0; eRst[1] = 1'b1; eOn[1] = 1'b0; eBusy = 1'b0; eIdx = 0;
        expectAt(p + 7, "tg1_redown_commit");
        tick(2);
        targetOn = 5'b11001;
        tick(10);

        // Down cluster 3, then a timeout on cluster 0 leaving err_o[0] set
        stuck0[0] = 1'b1;
        t0 = cyc; targetOn = 5'b10000;
        eIso[3] = 1'b1; eBusy = 1'b1; eIdx = 3;     expectAt(t0 + 1, "d3_iso");
        eClk[3] = 1'b0; eRst[3] = 1'b1; eOn[3] = 1'b0; eBusy = 1'b0; eIdx = 0;
        expectAt(t0 + 2, "d3_commit");
        q = t0 + 3;
        eIso[0] = 1'b1; eBusy = 1'b1; eIdx = 0;     expectAt(q, "to0_iso");
        eIso[0] = 1'b0; eErr[0] = 1'b1; eBusy = 1'b0;
        expectAt(q + 8, "to0_abort");
        tick(14);

        // Power up cluster 3, stall in UpDeiso, reset mid-sequence
        stuck1[3] = 1'b1;
        t1 = cyc; targetOn = 5'b11000;
        p = t1 + 1;
        eClk[3] = 1'b1; eBusy = 1'b1; eIdx = 3;     expectAt(p, "up3_clk_en");
        eRst[3] = 1'b0; eIso[3] = 1'b0;             expectAt(p + 4, "up3_rst_release");
        tick(6);
        rst = 1'b1; targetOn = '0; stuck0 = '0; stuck1 = '0;
        setResetShadow();
        expectAt(0, "reset_mid_deiso");
        tick(2);
        rst = 1'b0;
        tick(5);

        nChecks++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL missing_events: got %0d expected events left, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
